// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// Bounded bursts per grant, one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   wr_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_q;
  logic [BW-1:0] burst_q;
  logic [15:0]   wr_cnt_q;
  logic [15:0]   wr_cnt_d;

  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic [IW-1:0] next_ptr;
  logic          granted;
  logic          xfer;

  assign granted  = (state_q == GRANT);
  assign xfer     = granted && req_valid[grant_q] && !fifo_full;
  assign wr_cnt_d = wr_cnt_q + 16'd1;
  assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (req_valid[cand[IW-1:0]])
        pick = cand[IW-1:0];
    end
  end

  // Zero-latency write path from the granted requester.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = xfer;
    fifo_data_in = '0;
    if (granted && !fifo_full)
      req_ready = NUM_REQ'(1) << grant_q;
    if (xfer)
      fifo_data_in = req_data[grant_q*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Arbitration FSM; pointer moves past the grantee on every release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= pick;
            burst_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[grant_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end else if (xfer) begin
            wr_cnt_q <= wr_cnt_d;
            burst_q  <= burst_q + 1'b1;
            if (burst_q == BW'(MAX_BURST - 1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = granted;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle tables, burst scoreboard,
// mid-burst reset and write-counter wrap on a wide-burst instance.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  logic        rst2_n;
  logic [1:0]  req_valid2;
  logic [31:0] req_data2;
  logic [1:0]  req_ready2;
  logic        fifo_full2;
  logic        fifo_wr_en2;
  logic [15:0] fifo_data_in2;
  logic [0:0]  grant_id2;
  logic        busy2;
  logic [15:0] wr_count2;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(2), .MAX_BURST(16)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .fifo_full(fifo_full2),
    .fifo_wr_en(fifo_wr_en2), .fifo_data_in(fifo_data_in2),
    .grant_id(grant_id2), .busy(busy2), .wr_count(wr_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic        full;
    logic [1:0]  src;
    logic [15:0] din;
    logic        busy;
    logic [1:0]  gid;
    logic [3:0]  rdy;
    logic        wen;
    logic [15:0] dout;
    logic [15:0] wcnt;
  } vec_t;

  typedef struct {
    logic [1:0]  gid;
    logic [15:0] data;
  } wr_t;

  vec_t tbl[24];
  wr_t  sb[$];

  function automatic vec_t mk(
    logic [3:0] v, logic f, logic [1:0] s, logic [15:0] d,
    logic b, logic [1:0] g, logic [3:0] r, logic w,
    logic [15:0] o, logic [15:0] c);
    vec_t x;
    x.vld = v; x.full = f; x.src = s; x.din = d;
    x.busy = b; x.gid = g; x.rdy = r; x.wen = w;
    x.dout = o; x.wcnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic outs(output logic [39:0] o);
    o = {busy, grant_id, req_ready, fifo_wr_en, fifo_data_in, wr_count};
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    rst2_n = 1'b0; req_valid2 = '0; req_data2 = 32'h2222_1111;
    fifo_full2 = 1'b0;
    fork
      begin : main_seq
        int n;
        logic [39:0] o;
        int seqd[4];
        int pushed[4];
        int order[5];
        wr_t e;
        logic ew;
        n = 0;
        for (int k = 0; k < 5; k++)
          tbl[n++] = mk(4'h0, 0, 0, 16'h0, 0, 0, 4'h0, 0, 16'h0, 16'd0);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A0, 0, 0, 4'h0, 0, 16'h0, 16'd0);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A0, 1, 2, 4'h4, 1, 16'h00A0, 16'd0);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A1, 1, 2, 4'h4, 1, 16'h00A1, 16'd1);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A2, 1, 2, 4'h4, 1, 16'h00A2, 16'd2);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A3, 1, 2, 4'h4, 1, 16'h00A3, 16'd3);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A4, 0, 2, 4'h0, 0, 16'h0, 16'd4);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A4, 1, 2, 4'h4, 1, 16'h00A4, 16'd4);
        tbl[n++] = mk(4'h4, 0, 2, 16'h00A5, 1, 2, 4'h4, 1, 16'h00A5, 16'd5);
        tbl[n++] = mk(4'h0, 0, 2, 16'h00A6, 1, 2, 4'h4, 0, 16'h0, 16'd6);
        tbl[n++] = mk(4'h0, 0, 2, 16'h00A6, 0, 2, 4'h0, 0, 16'h0, 16'd6);
        tbl[n++] = mk(4'h2, 0, 1, 16'h00B0, 0, 2, 4'h0, 0, 16'h0, 16'd6);
        tbl[n++] = mk(4'h2, 0, 1, 16'h00B0, 1, 1, 4'h2, 1, 16'h00B0, 16'd6);
        tbl[n++] = mk(4'h2, 0, 1, 16'h00B1, 1, 1, 4'h2, 1, 16'h00B1, 16'd7);
        for (int k = 0; k < 3; k++)
          tbl[n++] = mk(4'h2, 1, 1, 16'h00B2, 1, 1, 4'h0, 0, 16'h0, 16'd8);
        tbl[n++] = mk(4'h2, 0, 1, 16'h00B2, 1, 1, 4'h2, 1, 16'h00B2, 16'd8);
        tbl[n++] = mk(4'h2, 0, 1, 16'h00B3, 1, 1, 4'h2, 1, 16'h00B3, 16'd9);
        tbl[n++] = mk(4'h0, 0, 1, 16'h00B4, 0, 1, 4'h0, 0, 16'h0, 16'd10);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < n; r++) begin
          @(negedge clk);
          req_valid = tbl[r].vld;
          fifo_full = tbl[r].full;
          for (int i = 0; i < 4; i++)
            req_data[i*16 +: 16] = (i == int'(tbl[r].src)) ? tbl[r].din
                                   : (16'hBAD0 | 16'(i));
          #1;
          outs(o);
          chk($sformatf("row%0d", r), 64'(o),
              64'({tbl[r].busy, tbl[r].gid, tbl[r].rdy, tbl[r].wen,
                   tbl[r].dout, tbl[r].wcnt}));
        end

        // All four requesters: grant order 0,1,2,3,0.
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin seqd[i] = 0; pushed[i] = 0; end
        for (int b = 0; b < 5; b++)
          for (int k = 0; k < 4; k++) begin
            e.gid = 2'(order[b]);
            e.data = {4'(order[b]), 12'(pushed[order[b]])};
            pushed[order[b]]++;
            sb.push_back(e);
          end
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          req_valid = 4'hF;
          for (int i = 0; i < 4; i++)
            req_data[i*16 +: 16] = {4'(i), 12'(seqd[i])};
          #1;
          ew = ((c % 5) != 0);
          chk($sformatf("rr_wen%0d", c), 64'({busy, fifo_wr_en}),
              64'({ew, ew}));
          if (fifo_wr_en && ew) begin
            if (sb.size() == 0) begin
              chk("rr_sb_empty", 64'(sb.size()), 64'd1);
            end else begin
              e = sb.pop_front();
              chk($sformatf("rr_wr%0d", c),
                  64'({grant_id, req_ready, fifo_data_in}),
                  64'({e.gid, 4'(1) << e.gid, e.data}));
              seqd[e.gid]++;
            end
          end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rr_left", 64'(sb.size()), 64'd0);
        chk("rr_count", 64'(wr_count), 64'd20);

        // Reset during requester 3's third write.
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          req_valid = 4'h8;
          for (int i = 0; i < 4; i++)
            req_data[i*16 +: 16] = 16'hC000 | 16'(i << 8) | 16'(c);
          #1;
          if (c == 3)
            chk("rst_pre", 64'({busy, grant_id, fifo_wr_en, fifo_data_in}),
                64'({1'b1, 2'd3, 1'b1, 16'hC303}));
        end
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        outs(o);
        chk("rst_mid", 64'(o), 64'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        outs(o);
        chk("rst_idle", 64'(o), 64'd0);
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_arb", 64'({busy, fifo_wr_en}), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_first", 64'({busy, grant_id, fifo_wr_en, fifo_data_in}),
            64'({1'b1, 2'd0, 1'b1, 16'hC003}));
        req_valid = '0;
      end
      begin : wrap_seq
        int m;
        bit done;
        m = 0;
        done = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        req_valid2 = 2'b11;
        for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
          @(negedge clk);
          #1;
          if (m >= 65534) begin
            chk("wrap_cnt", 64'(wr_count2), 64'(m[15:0]));
            if (m == 65537) done = 1'b1;
          end
          if (fifo_wr_en2) m++;
        end
        if (!done) chk("wrap_timeout", 64'(m), 64'd65537);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, SHALL set the data width of every requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (legal range 2..8).
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive writes per grant (legal range 1..16).
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 Port req_valid  input  NUM_REQ  SHALL be the per-requester write request, bit i for requester i.
REQ-007 Port req_data  input  NUM_REQ*FIFO_WIDTH  SHALL carry the requester data, slice i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 Port req_ready  output  NUM_REQ  SHALL be the one-hot-or-zero per-requester accept.
REQ-009 Port fifo_full  input  1  SHALL be the full flag of the downstream FIFO.
REQ-010 Port fifo_wr_en  output  1  SHALL drive the FIFO write enable.
REQ-011 Port fifo_data_in  output  FIFO_WIDTH  SHALL drive the FIFO write data.
REQ-012 Port grant_id  output  $clog2(NUM_REQ)  SHALL report the currently granted requester.
REQ-013 Port busy  output  1  SHALL be high while the FSM is in GRANT.
REQ-014 Port wr_count  output  16  SHALL count accepted writes and wrap from 0xFFFF to 0x0000.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE with any req_valid bit high, the FSM SHALL select the first requester with req_valid high, searching upward from rr_ptr modulo NUM_REQ; it SHALL register that index into grant_id, clear burst_cnt, and enter GRANT on the next edge.
REQ-017 In IDLE, req_ready SHALL be all-zero and fifo_wr_en SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 A transfer SHALL occur in a cycle where req_valid[grant_id] and req_ready[grant_id] are both high.
REQ-020 fifo_wr_en SHALL equal the transfer condition and fifo_data_in SHALL equal req_data slice grant_id in the same cycle (zero latency); fifo_data_in SHALL be 0 when no transfer occurs.
REQ-021 Each transfer SHALL increment burst_cnt and wr_count by 1.
REQ-022 A transfer with burst_cnt == MAX_BURST-1 SHALL return the FSM to IDLE on the next edge.
REQ-023 In GRANT, req_valid[grant_id] low SHALL return the FSM to IDLE on the next edge with no transfer.
REQ-024 On every GRANT->IDLE transition, rr_ptr SHALL load (grant_id+1) mod NUM_REQ.
REQ-025 While fifo_full is high, the grant SHALL be held indefinitely, with no transfer and no burst_cnt change.
REQ-026 A requester SHALL NOT receive two consecutive grants while another requester has req_valid high at arbitration time.
REQ-027 Re-arbitration SHALL cost exactly one IDLE cycle between grants.
REQ-028 fifo_wr_en SHALL never be high while fifo_full is high.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, rr_ptr 0, grant_id 0, burst_cnt 0, wr_count 0, busy 0, req_ready 0, fifo_wr_en 0, fifo_data_in 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no write issued in that cycle; after release, arbitration SHALL restart from requester 0.

Verification
REQ-031 Reset and release with all req_valid low -> outputs stay at reset values and busy=0 for 5 cycles.
REQ-032 Requester 2 alone holds req_valid with data 0x00A0..0x00A5 and fifo_full=0 -> IDLE, then 4 writes 0x00A0..0x00A3 on consecutive cycles, 1 IDLE cycle, then 0x00A4..0x00A5; wr_count=6.
REQ-033 All four requesters valid continuously -> grant order 0,1,2,3,0, each burst 4 writes, one IDLE cycle between grants.
REQ-034 fifo_full asserted for 3 cycles after requester 1's second write -> req_ready=0 and fifo_wr_en=0 for those 3 cycles, grant_id stays 1, burst resumes at write 3.
REQ-035 rst_n pulsed low during requester 3's third write -> no fifo_wr_en that cycle; after release, requester 0 is granted first when valid.
REQ-036 Starting from wr_count=0xFFFE, 3 writes -> wr_count reads 0xFFFF, then 0x0000, then 0x0001.
